// File: rtl/tp_pkg.sv
// tp_pkg: shared widths, tags, enums and word-class decode for the TP stream
package tp_pkg;
    localparam int TP_W = 65;
    localparam int TP_META_BIT = 64;
    localparam logic [3:0] TAG_HDR = 4'hA;
    localparam logic [3:0] TAG_FTR = 4'hF;
    typedef enum logic [1:0] {HDR, FTR, DATA, BADTAG} word_class_t;
    typedef enum logic {IDLE, BODY} state_t;
    function automatic word_class_t classify(input logic [TP_W-1:0] w);
        return !w[TP_META_BIT] ? DATA :
               w[63:60] == TAG_HDR ? HDR :
               w[63:60] == TAG_FTR ? FTR : BADTAG;
    endfunction
endpackage

// File: rtl/tp_sat_counter.sv
// tp_sat_counter: saturating up-counter with synchronous clear
module tp_sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) count <= '0;
        else if (clr) count <= '0;
        else if (inc && count != '1) count <= count + WIDTH'(1);
    end
endmodule

// File: rtl/tp_stream_rx.sv
// tp_stream_rx: event framer for the TP stream, forwards payload and reports per-event status
module tp_stream_rx
    import tp_pkg::*;
#(
    parameter int W = TP_W,
    parameter int MAX_WORDS = 4096
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] din,
    input  logic         din_valid,
    output logic [W-2:0] data_out,
    output logic         data_out_valid,
    output logic         data_out_sof,
    output logic         event_done,
    output logic [31:0]  event_l1id,
    output logic [15:0]  event_nwords,
    output logic         event_err,
    output logic [31:0]  n_events,
    output logic [15:0]  n_errors
);
    state_t      state;
    word_class_t cls;
    logic [15:0] wcnt;
    logic [31:0] cur_l1id;
    logic        err_flag, sof_pend, in_body, ftr_err, closing, wc_clr, wc_inc, err_inc;
    always_comb begin
        cls = classify(din);
        in_body = state == BODY;
        ftr_err = wcnt != din[15:0] || int'(wcnt) > MAX_WORDS || err_flag;
        closing = din_valid && in_body && (cls == HDR || cls == FTR);
        wc_clr = din_valid && cls == HDR;
        wc_inc = din_valid && in_body && cls == DATA;
        err_inc = din_valid && (in_body ? (cls == BADTAG || cls == HDR || (cls == FTR && ftr_err)) : cls != HDR);
    end
    tp_sat_counter #(.WIDTH(16)) u_wcnt (
        .clk(clk), .rst(rst), .clr(wc_clr), .inc(wc_inc), .count(wcnt)
    );
    tp_sat_counter #(.WIDTH(16)) u_nerr (
        .clk(clk), .rst(rst), .clr(1'b0), .inc(err_inc), .count(n_errors)
    );
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cur_l1id <= '0;
            err_flag <= 1'b0;
            sof_pend <= 1'b0;
            data_out <= '0;
            data_out_valid <= 1'b0;
            data_out_sof <= 1'b0;
            event_done <= 1'b0;
            event_l1id <= '0;
            event_nwords <= '0;
            event_err <= 1'b0;
            n_events <= '0;
        end else begin
            data_out_valid <= 1'b0;
            data_out_sof <= 1'b0;
            event_done <= 1'b0;
            // a header inside a body closes the old event and opens the new one in one cycle
            if (closing) begin
                event_done <= 1'b1;
                event_l1id <= cur_l1id;
                event_nwords <= wcnt;
                event_err <= cls == HDR || ftr_err;
                n_events <= n_events + 32'd1;
            end
            if (din_valid && cls == HDR) begin
                state <= BODY;
                cur_l1id <= din[31:0];
                err_flag <= 1'b0;
                sof_pend <= 1'b1;
            end
            if (din_valid && in_body && cls == FTR) state <= IDLE;
            if (din_valid && in_body && cls == BADTAG) err_flag <= 1'b1;
            if (din_valid && in_body && cls == DATA) begin
                data_out <= din[W-2:0];
                data_out_valid <= 1'b1;
                data_out_sof <= sof_pend;
                sof_pend <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_tp_stream_rx.sv
// tb_tp_stream_rx: randomized bench for tp_stream_rx against a word-level event model
module tb_tp_stream_rx;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [64:0] din = '0;
    logic        din_valid = 1'b0;
    logic [63:0] data_out;
    logic        data_out_valid, data_out_sof, event_done, event_err;
    logic [31:0] event_l1id, n_events;
    logic [15:0] event_nwords, n_errors;
    int vectors = 0;
    int miscompares = 0;
    bit m_body, m_sof, m_err;
    logic [31:0] m_id;
    int m_cnt, m_events, m_errors;
    bit e_dv, e_sof, e_done, e_err;
    logic [63:0] e_data;
    logic [31:0] e_l1id;
    logic [15:0] e_nw;
    logic [63:0] sb[$];
    tp_stream_rx dut (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
        .data_out(data_out), .data_out_valid(data_out_valid), .data_out_sof(data_out_sof),
        .event_done(event_done), .event_l1id(event_l1id), .event_nwords(event_nwords),
        .event_err(event_err), .n_events(n_events), .n_errors(n_errors)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    function automatic logic [64:0] hdr(input logic [31:0] id);
        return {1'b1, 4'hA, 28'h0, id};
    endfunction
    function automatic logic [64:0] ftr(input logic [15:0] n);
        return {1'b1, 4'hF, 44'h0, n};
    endfunction
    function automatic logic [64:0] dat();
        return {1'b0, $urandom, $urandom};
    endfunction
    function automatic logic [64:0] bad();
        logic [3:0] t;
        do t = 4'($urandom); while (t == 4'hA || t == 4'hF);
        return {1'b1, t, 28'($urandom), $urandom};
    endfunction
    task automatic model_reset();
        m_body = 0; m_sof = 0; m_err = 0; m_id = '0; m_cnt = 0;
        m_events = 0; m_errors = 0;
        e_l1id = '0; e_nw = '0; e_err = 0;
    endtask
    task automatic model(input logic [64:0] w);
        bit h, f, d;
        h = w[64] && w[63:60] == 4'hA;
        f = w[64] && w[63:60] == 4'hF;
        d = !w[64];
        if (m_body && (h || f)) begin
            e_done = 1;
            e_l1id = m_id;
            e_nw = 16'(m_cnt);
            e_err = h || m_cnt != int'(w[15:0]) || m_cnt > 4096 || m_err;
            m_events++;
            if (e_err) m_errors++;
        end
        if (!m_body && !h) m_errors++;
        if (m_body && !h && !f && !d) begin
            m_err = 1;
            m_errors++;
        end
        if (m_body && d) begin
            e_dv = 1;
            e_sof = m_sof;
            e_data = w[63:0];
            m_sof = 0;
            if (m_cnt < 65535) m_cnt++;
        end
        if (m_body && f) m_body = 0;
        if (h) begin
            m_body = 1; m_id = w[31:0]; m_cnt = 0; m_err = 0; m_sof = 1;
        end
        if (m_errors > 65535) m_errors = 65535;
    endtask
    task automatic cycle(input bit v, input logic [64:0] w);
        din_valid = v;
        din = w;
        @(posedge clk);
        #1;
        e_dv = 0; e_sof = 0; e_done = 0;
        if (v) model(w);
        check("data_out_valid", data_out_valid, e_dv);
        if (e_dv) begin
            check("data_out", data_out, e_data);
            check("data_out_sof", data_out_sof, e_sof);
        end
        if (data_out_valid && sb.size() > 0) check("payload_sb", data_out, sb.pop_front());
        check("event_done", event_done, e_done);
        check("event_l1id", event_l1id, e_l1id);
        check("event_nwords", event_nwords, e_nw);
        check("event_err", event_err, e_err);
        check("n_events", n_events, m_events);
        check("n_errors", n_errors, m_errors);
    endtask
    task automatic send(input logic [64:0] w);
        cycle(1'b1, w);
    endtask
    task automatic do_reset();
        din_valid = 0;
        rst = 0;
        #2;
        check("rst_data_out", data_out, 0);
        check("rst_dv", data_out_valid, 0);
        check("rst_sof", data_out_sof, 0);
        check("rst_done", event_done, 0);
        check("rst_l1id", event_l1id, 0);
        check("rst_nwords", event_nwords, 0);
        check("rst_err", event_err, 0);
        check("rst_n_events", n_events, 0);
        check("rst_n_errors", n_errors, 0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1;
    endtask
    initial begin
        int base;
        model_reset();
        repeat (2) @(posedge clk);
        do_reset();
        send(hdr(32'h12));
        repeat (3) send(dat());
        send(ftr(16'd3));
        check("t1_l1id", event_l1id, 32'h12);
        check("t1_nwords", event_nwords, 3);
        check("t1_err", event_err, 0);
        check("t1_n_events", n_events, 1);
        send(hdr(32'h12));
        repeat (3) send(dat());
        send(ftr(16'd5));
        check("t2_err", event_err, 1);
        check("t2_nwords", event_nwords, 3);
        check("t2_n_errors", n_errors, 1);
        base = int'(n_errors);
        send(dat());
        send(ftr(16'd0));
        check("t3_n_errors", n_errors, 64'(base + 2));
        send(hdr(32'hA));
        repeat (2) send(dat());
        send(hdr(32'hB));
        check("t4a_l1id", event_l1id, 32'hA);
        check("t4a_err", event_err, 1);
        check("t4a_nwords", event_nwords, 2);
        send(dat());
        send(ftr(16'd1));
        check("t4b_l1id", event_l1id, 32'hB);
        check("t4b_err", event_err, 0);
        check("t4b_nwords", event_nwords, 1);
        send(hdr(32'h77));
        send(ftr(16'd0));
        check("hdr_only_err", event_err, 0);
        check("hdr_only_nwords", event_nwords, 0);
        send(hdr(32'h100));
        repeat (4096) send(dat());
        send(ftr(16'd4096));
        check("max_ok_err", event_err, 0);
        send(hdr(32'h101));
        repeat (4097) send(dat());
        send(ftr(16'd4097));
        check("over_max_err", event_err, 1);
        check("over_max_nwords", event_nwords, 4097);
        do_reset();
        for (int e = 0; e < 100; e++) begin
            logic [64:0] w;
            for (int k = 0; k < 6; k++) begin
                while ($urandom_range(3) == 0) cycle(1'b0, dat());
                w = k == 0 ? hdr($urandom) : k == 5 ? ftr(16'd4) : dat();
                if (k > 0 && k < 5) sb.push_back(w[63:0]);
                send(w);
            end
        end
        check("stream_n_events", n_events, 100);
        check("stream_n_errors", n_errors, 0);
        check("stream_sb_empty", 64'(sb.size()), 0);
        for (int i = 0; i < 400; i++) begin
            int r;
            logic [64:0] w;
            r = int'($urandom_range(9));
            w = r < 2 ? hdr($urandom) : r == 2 ? ftr(16'($urandom_range(4))) : r == 3 ? bad() : dat();
            cycle($urandom_range(4) != 0, w);
        end
        send(hdr(32'h55));
        repeat (2) send(dat());
        do_reset();
        send(hdr(32'h66));
        repeat (2) send(dat());
        send(ftr(16'd2));
        check("post_rst_l1id", event_l1id, 32'h66);
        check("post_rst_n_events", n_events, 1);
        check("post_rst_err", event_err, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/tp_stream_rx.md
# tp_stream_rx

Receive-side framer for the 65-bit TP word stream (bit 64 = metadata flag) emitted by `tp` on `dout`/`dout_valid`. It delimits events by their header and footer metadata words and forwards payload words with start-of-event marking. Per event it reports the ID, word count and framing errors. It sits downstream of `tp`, both in the top-level bench and in the output path of the main FPGA.

## Interface
Parameters:
- `W`, 65, stream word width including metadata flag at bit `W-1`.
- `MAX_WORDS`, 4096, largest legal payload word count per event; larger counts are flagged as errors.

Ports:
- `clk`  in  1  single clock for the whole block.
- `rst`  in  1  reset, asynchronous, active-low.
- `din`  in  W  stream word; connects to `tp.dout`.
- `din_valid`  in  1  `din` is valid this cycle; connects to `tp.dout_valid`. There is no backpressure.
- `data_out`  out  W-1  payload word, with the metadata bit stripped.
- `data_out_valid`  out  1  `data_out` is valid.
- `data_out_sof`  out  1  first payload word of an event.
- `event_done`  out  1  one-cycle pulse when an event closes.
- `event_l1id`  out  32  ID of the event that closed; held until the next `event_done`.
- `event_nwords`  out  16  payload words received; held until the next `event_done`.
- `event_err`  out  1  closed event had a framing error; held until the next `event_done`.
- `n_events`  out  32  events closed, counted with or without error; wraps.
- `n_errors`  out  16  framing errors of all kinds; saturates at 16'hFFFF.

## Operation
- Word classes are decoded from `din`:
  - Header: bit 64 = 1 and `[63:60]` = 4'hA. Bits `[31:0]` carry the L1ID.
  - Footer: bit 64 = 1 and `[63:60]` = 4'hF. Bits `[15:0]` carry the declared payload count.
  - Data: bit 64 = 0.
  - Bad tag: bit 64 = 1 with any other `[63:60]`.
- The FSM has two states, IDLE and BODY. Reset enters IDLE.
- IDLE:
  - Header: latch the L1ID, clear the word counter and the error flag, set the sof-pending flag, go to BODY.
  - Data: orphan; dropped, `n_errors`++.
  - Footer: orphan; dropped, `n_errors`++.
  - Bad tag: `n_errors`++, stay in IDLE.
- BODY:
  - Data: forward on `data_out`. Assert `data_out_sof` if sof-pending, then clear sof-pending. Counter++ (16-bit, saturating).
  - Footer: close the event. `event_err` = (counter != declared count) OR (counter > `MAX_WORDS`) OR the accumulated error flag. `n_errors`++ once if `event_err`. Go to IDLE.
  - Header (missing footer): close the current event with `event_err` = 1, `n_errors`++. Start the new event in the same cycle with the new L1ID, counter 0 and sof-pending. Stay in BODY.
  - Bad tag: set the error flag, `n_errors`++, stay in BODY. The word is not forwarded.
- Cycles with `din_valid` = 0 are ignored in every state; state and counters hold.
- A header-only event (header then footer) closes with `event_nwords` = 0, emits no data words, and has `event_err` = 0 if the declared count is 0.

## Timing
- All outputs are registered. Reset value of every output is 0.
- Data latency is 1 cycle: a data word accepted at edge N appears on `data_out`/`data_out_valid` after edge N and is valid until edge N+1.
- `event_done` pulses for one cycle, 1 cycle after the closing footer or header is accepted. `event_l1id`, `event_nwords` and `event_err` update in that same cycle.
- Back-to-back valid words at full rate are sustained with no bubbles.
- Footer immediately followed by header: `event_done` for the first event and the new header are processed without loss.
- Reset mid-event: asynchronous clear to IDLE and all outputs to 0. The partial event is discarded and not counted.
- `n_errors` increments at most once per accepted word.

## Structure
- Shared package `tp_pkg` holds:
  - `TP_W` = 65 and `TP_META_BIT` = 64.
  - `TAG_HDR` = 4'hA and `TAG_FTR` = 4'hF.
  - The word-class enum (HDR, FTR, DATA, BADTAG) and the FSM state enum (IDLE, BODY).
- A word-class decode function lives in `tp_pkg`.
- One sub-module, `tp_sat_counter` (parameterised width, inc/clr, saturating), is instantiated for the word counter and for `n_errors`.

## Test plan
- Header L1ID 32'h12, 3 data words, footer count 3:
  - 3 `data_out_valid` cycles, sof on the first.
  - `event_done` with `event_l1id` = 32'h12, `event_nwords` = 3, `event_err` = 0.
  - `n_events` = 1.
- Same event, but footer declares 5: `event_err` = 1, `event_nwords` = 3, `n_errors` = 1.
- Data word then footer while in IDLE: no `data_out_valid`, no `event_done`, `n_errors` = 2.
- Header A, 2 data words, header B, 1 data word, footer count 1:
  - First `event_done` for A with `event_err` = 1, `event_nwords` = 2.
  - Second `event_done` for B with `event_err` = 0, `event_nwords` = 1.
  - Sof asserted on the first word of each event.
- Full-rate stream of 100 events (header, 4 data words, footer) with random `din_valid` gaps: `n_events` = 100, `n_errors` = 0, payload matches the scoreboard.
- `rst` asserted low mid-event after 2 data words: all outputs 0 immediately. A fresh event after release is reported correctly, with `n_events` = 1.
